modexp_hs: RTL
==============

# modexp_hs

Handshaked, multi-cycle RSA modular-exponentiation engine that computes m_out = c_in^d mod n by left-to-right square-and-multiply over a bit-serial modular multiplier. It is the decrypt-side counterpart to the fixed-latency, reset-started `modexp` encryptor: a start/done handshake replaces "release reset and wait CC cycles", and latency depends on the exponent. It sits between the ciphertext source and the plaintext consumer in the RSA datapath.

## Interface
- `N`, default 8: operand width in bits for c_in, d, n and m_out.
- `clk`  in  1  Single clock; all state changes on the rising edge.
- `rst`  in  1  Reset, synchronous and active-high.
- `start`  in  1  One-cycle request. Sampled only when `busy`=0.
- `c_in`  in  N  Base (ciphertext). Precondition: c_in < n.
- `d`  in  N  Exponent.
- `n`  in  N  Modulus. Precondition: n ≥ 2.
- `busy`  out  1  High from the cycle after an accepted start until `done`.
- `done`  out  1  One-cycle pulse; `m_out` and `err` are valid in this cycle.
- `m_out`  out  N  Result. Held from `done` until the next accepted start.
- `err`  out  1  Precondition violation flag, held like `m_out`.

## Operation
- Operands are latched on an accepted start. Input changes while busy have no effect.
- FSM states: IDLE, LOAD, SQ, MUL, FIN.
  - **IDLE**, with start=1: latch operands, go to LOAD.
  - **LOAD**, 1 cycle:
    - If n<2 or c_in≥n: err=1, m_out=0, go to FIN.
    - If d=0: r=1, go to FIN.
    - Otherwise: r=c_in, k=msb(d)−1. If k<0, go to FIN; else go to SQ.
  - **SQ**: r = r·r mod n. Then go to MUL if d[k]=1, otherwise decrement k, and go to FIN if k<0, else SQ.
  - **MUL**: r = r·c_in mod n. Then decrement k, and go to FIN if k<0, else SQ.
  - **FIN**, 1 cycle: m_out=r, done=1, busy=0, go to IDLE.
- Each SQ or MUL occupies exactly N+1 cycles: 1 launch cycle plus N iteration cycles of the `modmul_serial` multiplier.
- Modular multiply a·b mod n, with a, b < n, uses interleaved shift-add, MSB of b first, N iterations:
  - acc ← 2·acc; if acc ≥ n, acc −= n.
  - If b[i]: acc += a; if acc ≥ n, acc −= n.
  - Internal accumulator width is N+1 bits. No intermediate value exceeds 2n−1.
- start while busy: ignored; not queued.
- start in the same cycle as FIN: ignored. Start is accepted from IDLE only, which is the cycle after done.
- rst mid-operation: next cycle is IDLE with every output at its reset value. Any partial result is discarded.
- Reset values: busy=0, done=0, m_out=0, err=0.

## Timing
- Start is sampled at edge 0. done is high during the cycle after edge L, where:
  - d=0, d=1, or error: L = 3 (LOAD + FIN).
  - d ≥ 2: L = 3 + (N+1)·(msb(d) + popcount(d) − 1).
- busy goes high at edge 1 and low together with the done pulse.
- The back-to-back rate is one start per L+1 cycles.

## Structure
- Shared header/package `rsa_defs`: FSM state encodings and the `msb` index helper function, both reused by `modexp`-family blocks.
- One sub-module, `modmul_serial`.
  - Ports: clk, rst, go, a, b, n, rdy, p.
  - Fixed N-cycle latency; rdy pulses with p valid.
  - It is the only arithmetic in the block.
- The top level holds the FSM, the bit index k, and the registers r, c_in, d and n.

## Test plan
- N=8, c_in=98, d=35, n=221 → m_out=106, err=0, done exactly 3+9·7=66 cycles after start. This is the decrypt of 106^11 mod 221 = 98.
- d=0, c_in=5, n=221 → m_out=1 at L=3. d=1, c_in=200 → m_out=200 at L=3.
- c_in=221, n=221 → err=1, m_out=0 at L=3. Repeat with n=1 → err=1.
- Re-pulse start during busy with different operands → result is still for the original operands, and exactly one done pulse is produced.
- Assert rst midway through a SQ → the next cycle shows busy=0, done=0, m_out=0. A subsequent start with c_in=98, d=35, n=221 → m_out=106.
- Random sweep, N=8, n ≥ 2, c_in < n → m_out matches a behavioural square-and-multiply reference function, and latency matches the formula.

Source files
------------

// File: rtl/rsa_defs.sv
// Shared definitions for the modexp family: FSM state encoding and the
// index-of-highest-set-bit helper used to seed the exponent scan.
package rsa_defs;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SQ,
        ST_MUL,
        ST_FIN
    } state_t;

    // Position of the most significant 1; returns 0 for a zero input.
    function automatic int msb_idx(input logic [31:0] v);
        int idx;
        idx = 0;
        for (int i = 0; i < 32; i++) begin
            if (v[i]) idx = i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/modexp_hs_if.sv
// Start/done handshake and operand bus of the modular-exponentiation engine.
interface modexp_hs_if #(
    parameter int N = 8
);
    logic         start;
    logic [N-1:0] c_in;
    logic [N-1:0] d;
    logic [N-1:0] n;
    logic         busy;
    logic         done;
    logic [N-1:0] m_out;
    logic         err;

    modport master (
        output start, c_in, d, n,
        input  busy, done, m_out, err
    );

    modport slave (
        input  start, c_in, d, n,
        output busy, done, m_out, err
    );
endinterface

// File: rtl/modmul_serial.sv
// Bit-serial modular multiplier p = a*b mod n (a, b < n), MSB of b first.
// The go cycle performs the first iteration, so rdy/p appear N cycles after go.
module modmul_serial #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         go,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [N-1:0] n,
    output logic         rdy,
    output logic [N-1:0] p
);
    localparam int CW = $clog2(N + 1);

    logic [N:0]    acc_reg;
    logic [N-1:0]  a_reg, b_reg, n_reg, p_reg;
    logic [CW-1:0] cnt_reg;
    logic          active_reg, rdy_reg;

    logic [N:0]    src_acc, src_a, src_n;
    logic          src_bit;
    logic [N:0]    dbl, dbl_red, sum, acc_step;

    // On go the iteration runs straight from the ports with a cleared accumulator.
    always_comb begin
        src_acc  = go ? '0 : acc_reg;
        src_a    = go ? {1'b0, a} : {1'b0, a_reg};
        src_n    = go ? {1'b0, n} : {1'b0, n_reg};
        src_bit  = go ? b[N-1] : b_reg[N-1];
        dbl      = {src_acc[N-1:0], 1'b0};
        dbl_red  = (dbl >= src_n) ? dbl - src_n : dbl;
        sum      = src_bit ? dbl_red + src_a : dbl_red;
        acc_step = (sum >= src_n) ? sum - src_n : sum;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_reg    <= '0;
            a_reg      <= '0;
            b_reg      <= '0;
            n_reg      <= '0;
            p_reg      <= '0;
            cnt_reg    <= '0;
            active_reg <= 1'b0;
            rdy_reg    <= 1'b0;
        end else begin
            rdy_reg <= 1'b0;
            if (go) begin
                acc_reg <= acc_step;
                a_reg   <= a;
                b_reg   <= b << 1;
                n_reg   <= n;
                cnt_reg <= CW'(N - 1);
                if (N == 1) begin
                    rdy_reg    <= 1'b1;
                    p_reg      <= acc_step[N-1:0];
                    active_reg <= 1'b0;
                end else begin
                    active_reg <= 1'b1;
                end
            end else if (active_reg) begin
                acc_reg <= acc_step;
                b_reg   <= b_reg << 1;
                cnt_reg <= cnt_reg - CW'(1);
                if (cnt_reg == CW'(1)) begin
                    active_reg <= 1'b0;
                    rdy_reg    <= 1'b1;
                    p_reg      <= acc_step[N-1:0];
                end
            end
        end
    end

    assign rdy = rdy_reg;
    assign p   = p_reg;
endmodule

// File: rtl/modexp_hs.sv
// Handshaked left-to-right square-and-multiply engine: m_out = c_in^d mod n.
// Latency depends on the exponent; busy/done frame each accepted request.
module modexp_hs
    import rsa_defs::*;
#(
    parameter int N = 8
) (
    input  logic        clk,
    input  logic        rst,
    modexp_hs_if.slave  bus
);
    localparam int KW = (N > 1) ? $clog2(N) : 1;

    state_t        state_reg;
    logic          start_reg;
    logic [N-1:0]  c_reg, d_reg, n_reg, r_reg, m_out_reg;
    logic [KW-1:0] k_reg;
    logic          err_flag_reg;
    logic          busy_reg, done_reg, err_reg, go_reg;

    logic          mul_rdy;
    logic [N-1:0]  mul_p, mul_b;
    logic [KW-1:0] top_bit;

    assign top_bit = KW'(msb_idx(32'(d_reg)));
    assign mul_b   = (state_reg == ST_MUL) ? c_reg : r_reg;

    modmul_serial #(.N(N)) u_mul (
        .clk (clk),
        .rst (rst),
        .go  (go_reg),
        .a   (r_reg),
        .b   (mul_b),
        .n   (n_reg),
        .rdy (mul_rdy),
        .p   (mul_p)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            start_reg    <= 1'b0;
            c_reg        <= '0;
            d_reg        <= '0;
            n_reg        <= '0;
            r_reg        <= '0;
            k_reg        <= '0;
            err_flag_reg <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            err_reg      <= 1'b0;
            m_out_reg    <= '0;
            go_reg       <= 1'b0;
        end else begin
            done_reg  <= 1'b0;
            go_reg    <= 1'b0;
            start_reg <= 1'b0;
            unique case (state_reg)
                // A sampled start is held one cycle so busy rises one edge later.
                ST_IDLE: begin
                    if (start_reg) begin
                        state_reg <= ST_LOAD;
                        busy_reg  <= 1'b1;
                    end else if (bus.start) begin
                        start_reg <= 1'b1;
                        c_reg     <= bus.c_in;
                        d_reg     <= bus.d;
                        n_reg     <= bus.n;
                    end
                end
                ST_LOAD: begin
                    err_flag_reg <= 1'b0;
                    if (n_reg < N'(2) || c_reg >= n_reg) begin
                        err_flag_reg <= 1'b1;
                        r_reg        <= '0;
                        state_reg    <= ST_FIN;
                    end else if (d_reg == '0) begin
                        r_reg     <= N'(1);
                        state_reg <= ST_FIN;
                    end else begin
                        r_reg <= c_reg;
                        if (top_bit == '0) begin
                            state_reg <= ST_FIN;
                        end else begin
                            k_reg     <= top_bit - KW'(1);
                            state_reg <= ST_SQ;
                            go_reg    <= 1'b1;
                        end
                    end
                end
                ST_SQ: begin
                    if (mul_rdy) begin
                        r_reg <= mul_p;
                        if (d_reg[k_reg]) begin
                            state_reg <= ST_MUL;
                            go_reg    <= 1'b1;
                        end else if (k_reg == '0) begin
                            state_reg <= ST_FIN;
                        end else begin
                            k_reg  <= k_reg - KW'(1);
                            go_reg <= 1'b1;
                        end
                    end
                end
                ST_MUL: begin
                    if (mul_rdy) begin
                        r_reg <= mul_p;
                        if (k_reg == '0) begin
                            state_reg <= ST_FIN;
                        end else begin
                            k_reg     <= k_reg - KW'(1);
                            state_reg <= ST_SQ;
                            go_reg    <= 1'b1;
                        end
                    end
                end
                ST_FIN: begin
                    m_out_reg <= r_reg;
                    err_reg   <= err_flag_reg;
                    done_reg  <= 1'b1;
                    busy_reg  <= 1'b0;
                    state_reg <= ST_IDLE;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy  = busy_reg;
    assign bus.done  = done_reg;
    assign bus.m_out = m_out_reg;
    assign bus.err   = err_reg;
endmodule
